// File: rtl/dqbp_sched.sv
// Column sequencer for the dtau/dq backward pass: walks links NUM_LINKS..1, fetches f and
// local df/dq, drives the combinational datapath and streams one dtau/dq per link.
module dqbp_sched #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DECIMAL_BITS = 16,
    parameter int unsigned NUM_LINKS    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_in,
    input  logic [2:0]       col_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             rd_req_out,
    output logic [2:0]       rd_link_out,
    input  logic             rd_valid_in,
    input  logic [WIDTH-1:0] rd_f_AX_in,
    input  logic [WIDTH-1:0] rd_f_AY_in,
    input  logic [WIDTH-1:0] rd_f_AZ_in,
    input  logic [WIDTH-1:0] rd_f_LX_in,
    input  logic [WIDTH-1:0] rd_f_LY_in,
    input  logic [WIDTH-1:0] rd_f_LZ_in,
    input  logic [WIDTH-1:0] rd_dfdq_AX_in,
    input  logic [WIDTH-1:0] rd_dfdq_AY_in,
    input  logic [WIDTH-1:0] rd_dfdq_AZ_in,
    input  logic [WIDTH-1:0] rd_dfdq_LX_in,
    input  logic [WIDTH-1:0] rd_dfdq_LY_in,
    input  logic [WIDTH-1:0] rd_dfdq_LZ_in,
    output logic [2:0]       dp_link_out,
    output logic             dp_fcross_out,
    output logic [WIDTH-1:0] dp_fcurr_AX_out,
    output logic [WIDTH-1:0] dp_fcurr_AY_out,
    output logic [WIDTH-1:0] dp_fcurr_AZ_out,
    output logic [WIDTH-1:0] dp_fcurr_LX_out,
    output logic [WIDTH-1:0] dp_fcurr_LY_out,
    output logic [WIDTH-1:0] dp_fcurr_LZ_out,
    output logic [WIDTH-1:0] dp_dfdq_curr_AX_out,
    output logic [WIDTH-1:0] dp_dfdq_curr_AY_out,
    output logic [WIDTH-1:0] dp_dfdq_curr_AZ_out,
    output logic [WIDTH-1:0] dp_dfdq_curr_LX_out,
    output logic [WIDTH-1:0] dp_dfdq_curr_LY_out,
    output logic [WIDTH-1:0] dp_dfdq_curr_LZ_out,
    output logic [WIDTH-1:0] dp_dfdq_prev_AX_out,
    output logic [WIDTH-1:0] dp_dfdq_prev_AY_out,
    output logic [WIDTH-1:0] dp_dfdq_prev_AZ_out,
    output logic [WIDTH-1:0] dp_dfdq_prev_LX_out,
    output logic [WIDTH-1:0] dp_dfdq_prev_LY_out,
    output logic [WIDTH-1:0] dp_dfdq_prev_LZ_out,
    input  logic [WIDTH-1:0] dp_dtau_in,
    input  logic [WIDTH-1:0] dp_dfdq_prev_AX_in,
    input  logic [WIDTH-1:0] dp_dfdq_prev_AY_in,
    input  logic [WIDTH-1:0] dp_dfdq_prev_AZ_in,
    input  logic [WIDTH-1:0] dp_dfdq_prev_LX_in,
    input  logic [WIDTH-1:0] dp_dfdq_prev_LY_in,
    input  logic [WIDTH-1:0] dp_dfdq_prev_LZ_in,
    output logic             dtau_valid_out,
    input  logic             dtau_ready_in,
    output logic [WIDTH-1:0] dtau_out,
    output logic [2:0]       dtau_link_out
);

    typedef enum logic [2:0] {
        StIdle, StFetchTop, StFetchPrev, StExec, StEmit, StDone
    } state_e;

    // Element order within a 6-vector: [0]=AX .. [5]=LZ.
    typedef logic [5:0][WIDTH-1:0] vec_t;

    localparam logic [2:0] TopLink = 3'(NUM_LINKS);

    vec_t rd_f, rd_dfdq, dp_prev_in;

    assign rd_f = {rd_f_LZ_in, rd_f_LY_in, rd_f_LX_in, rd_f_AZ_in, rd_f_AY_in, rd_f_AX_in};
    assign rd_dfdq = {rd_dfdq_LZ_in, rd_dfdq_LY_in, rd_dfdq_LX_in,
                      rd_dfdq_AZ_in, rd_dfdq_AY_in, rd_dfdq_AX_in};
    assign dp_prev_in = {dp_dfdq_prev_LZ_in, dp_dfdq_prev_LY_in, dp_dfdq_prev_LX_in,
                         dp_dfdq_prev_AZ_in, dp_dfdq_prev_AY_in, dp_dfdq_prev_AX_in};

    state_e     state_q, state_d;
    logic [2:0] i_q, i_d;
    logic [2:0] col_q, col_d;
    vec_t       f_q, f_d;
    vec_t       pf_q, pf_d;
    vec_t       acc_q, acc_d;
    vec_t       prev_q, prev_d;
    logic [WIDTH-1:0] dtau_q, dtau_d;
    logic [2:0] dtau_link_q, dtau_link_d;
    logic [2:0] dp_link_q, dp_link_d;
    logic       dp_fcross_q, dp_fcross_d;
    vec_t       dp_fcurr_q, dp_fcurr_d;
    vec_t       dp_curr_q, dp_curr_d;
    vec_t       dp_prev_q, dp_prev_d;
    logic       load_exec;

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        col_d       = col_q;
        f_d         = f_q;
        pf_d        = pf_q;
        acc_d       = acc_q;
        prev_d      = prev_q;
        dtau_d      = dtau_q;
        dtau_link_d = dtau_link_q;
        dp_link_d   = dp_link_q;
        dp_fcross_d = 1'b0;
        dp_fcurr_d  = dp_fcurr_q;
        dp_curr_d   = dp_curr_q;
        dp_prev_d   = dp_prev_q;
        load_exec   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    col_d   = col_in;
                    i_d     = TopLink;
                    state_d = StFetchTop;
                end
            end
            StFetchTop: begin
                if (rd_valid_in) begin
                    f_d     = rd_f;
                    acc_d   = rd_dfdq;
                    state_d = StFetchPrev;
                end
            end
            StFetchPrev: begin
                if (rd_valid_in) begin
                    prev_d    = rd_dfdq;
                    pf_d      = rd_f;
                    state_d   = StExec;
                    load_exec = 1'b1;
                end
            end
            StExec: begin
                // Integer and fraction fields pass through unchanged; no rescaling here.
                dtau_d      = {dp_dtau_in[WIDTH-1:DECIMAL_BITS], dp_dtau_in[DECIMAL_BITS-1:0]};
                dtau_link_d = i_q;
                acc_d       = dp_prev_in;
                f_d         = pf_q;
                state_d     = StEmit;
            end
            StEmit: begin
                if (dtau_ready_in) begin
                    if (i_q == 3'd1) begin
                        state_d = StDone;
                    end else begin
                        i_d = i_q - 3'd1;
                        // Link 1 has no parent to fetch: go straight to EXEC.
                        if (i_q == 3'd2) begin
                            prev_d    = '0;
                            state_d   = StExec;
                            load_exec = 1'b1;
                        end else begin
                            state_d = StFetchPrev;
                        end
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Datapath operands are registered on EXEC entry so they are glitch-free and hold after.
        if (load_exec) begin
            dp_link_d   = i_d;
            dp_fcross_d = (i_d == col_d);
            dp_fcurr_d  = f_d;
            dp_curr_d   = acc_d;
            dp_prev_d   = (i_d == 3'd1) ? '0 : prev_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            i_q         <= '0;
            col_q       <= '0;
            f_q         <= '0;
            pf_q        <= '0;
            acc_q       <= '0;
            prev_q      <= '0;
            dtau_q      <= '0;
            dtau_link_q <= '0;
            dp_link_q   <= '0;
            dp_fcross_q <= 1'b0;
            dp_fcurr_q  <= '0;
            dp_curr_q   <= '0;
            dp_prev_q   <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            col_q       <= col_d;
            f_q         <= f_d;
            pf_q        <= pf_d;
            acc_q       <= acc_d;
            prev_q      <= prev_d;
            dtau_q      <= dtau_d;
            dtau_link_q <= dtau_link_d;
            dp_link_q   <= dp_link_d;
            dp_fcross_q <= dp_fcross_d;
            dp_fcurr_q  <= dp_fcurr_d;
            dp_curr_q   <= dp_curr_d;
            dp_prev_q   <= dp_prev_d;
        end
    end

    always_comb begin
        rd_link_out = '0;
        if (state_q == StFetchTop) begin
            rd_link_out = TopLink;
        end else if (state_q == StFetchPrev) begin
            rd_link_out = i_q - 3'd1;
        end
    end

    assign busy_out       = (state_q != StIdle);
    assign done_out       = (state_q == StDone);
    assign rd_req_out     = (state_q == StFetchTop) || (state_q == StFetchPrev);
    assign dtau_valid_out = (state_q == StEmit);
    assign dtau_out       = dtau_q;
    assign dtau_link_out  = dtau_link_q;
    assign dp_link_out    = dp_link_q;
    assign dp_fcross_out  = dp_fcross_q;

    assign dp_fcurr_AX_out     = dp_fcurr_q[0];
    assign dp_fcurr_AY_out     = dp_fcurr_q[1];
    assign dp_fcurr_AZ_out     = dp_fcurr_q[2];
    assign dp_fcurr_LX_out     = dp_fcurr_q[3];
    assign dp_fcurr_LY_out     = dp_fcurr_q[4];
    assign dp_fcurr_LZ_out     = dp_fcurr_q[5];
    assign dp_dfdq_curr_AX_out = dp_curr_q[0];
    assign dp_dfdq_curr_AY_out = dp_curr_q[1];
    assign dp_dfdq_curr_AZ_out = dp_curr_q[2];
    assign dp_dfdq_curr_LX_out = dp_curr_q[3];
    assign dp_dfdq_curr_LY_out = dp_curr_q[4];
    assign dp_dfdq_curr_LZ_out = dp_curr_q[5];
    assign dp_dfdq_prev_AX_out = dp_prev_q[0];
    assign dp_dfdq_prev_AY_out = dp_prev_q[1];
    assign dp_dfdq_prev_AZ_out = dp_prev_q[2];
    assign dp_dfdq_prev_LX_out = dp_prev_q[3];
    assign dp_dfdq_prev_LY_out = dp_prev_q[4];
    assign dp_dfdq_prev_LZ_out = dp_prev_q[5];

endmodule
